// File: rtl/spi_sram_pkg.sv
// -----------------------------------------------------------------------------
// spi_sram_pkg
// Shared definitions for the SPI SRAM slave: opcode values, mode-register
// reset value and field decode, FSM state encoding.
// Optional feature macro: SPI_SRAM_FAST_READ_EN (enables opcode 0x0B).
// No ports (package).
// -----------------------------------------------------------------------------
package spi_sram_pkg;

  localparam logic [7:0] OP_WRMR      = 8'h01;
  localparam logic [7:0] OP_WRITE     = 8'h02;
  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_RDMR      = 8'h05;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;

  localparam logic [7:0] MR_RESET = 8'h40;

  // Encoding matches MR[7:6]; 2'b11 is never stored.
  typedef enum logic [1:0] {
    MODE_BYTE = 2'b00,
    MODE_SEQ  = 2'b01,
    MODE_PAGE = 2'b10
  } mode_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_RDMR,
    ST_WRMR,
    ST_IGNORE
  } state_t;

  // A mode-register write carrying the reserved mode 2'b11 leaves MR untouched.
  function automatic logic mr_write_ok(input logic [7:0] value);
    return value[7:6] != 2'b11;
  endfunction

endpackage

// File: rtl/spi_sram_slave_if.sv
// -----------------------------------------------------------------------------
// spi_sram_slave_if
// Bundles the SPI pins, status flags and parallel backdoor port of the SPI
// SRAM slave.
//   spi_cs_n/spi_sclk/spi_mosi : SPI inputs (mode 0, async to clk)
//   spi_miso                   : registered serial output
//   busy, cmd_err              : status (synchronized CS, sticky bad opcode)
//   bd_we/bd_addr/bd_wdata     : backdoor write; bd_rdata registered read
// Modports: slave (the SRAM), master (the bus driver / testbench).
// -----------------------------------------------------------------------------
interface spi_sram_slave_if #(
  parameter int AW = 16
);
  logic          spi_cs_n;
  logic          spi_sclk;
  logic          spi_mosi;
  logic          spi_miso;
  logic          busy;
  logic          cmd_err;
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [7:0]    bd_wdata;
  logic [7:0]    bd_rdata;

  modport slave (
    input  spi_cs_n, spi_sclk, spi_mosi, bd_we, bd_addr, bd_wdata,
    output spi_miso, busy, cmd_err, bd_rdata
  );

  modport master (
    output spi_cs_n, spi_sclk, spi_mosi, bd_we, bd_addr, bd_wdata,
    input  spi_miso, busy, cmd_err, bd_rdata
  );
endinterface

// File: rtl/spi_sram_sync.sv
// -----------------------------------------------------------------------------
// spi_sram_sync
// Brings the asynchronous SPI pins into the clk domain through SYNC_STAGES
// flops and detects SCLK edges with one extra flop.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   cs_n, sclk, mosi     : raw SPI pins
//   cs_act               : synchronized chip select, active high
//   sclk_rise, sclk_fall : single-cycle edge strobes of synchronized SCLK
//   mosi_s               : synchronized MOSI, aligned with the edge strobes
// -----------------------------------------------------------------------------
module spi_sram_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cs_n,
  input  logic sclk,
  input  logic mosi,
  output logic cs_act,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic mosi_s
);

  // Bit order in every stage: {cs_n, sclk, mosi}. Reset to "deselected, idle".
  localparam logic [2:0] STAGE_RESET = 3'b100;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      logic [2:0] q_reg;
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (!rst_n) q_reg <= STAGE_RESET;
          else        q_reg <= {cs_n, sclk, mosi};
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (!rst_n) q_reg <= STAGE_RESET;
          else        q_reg <= g_stage[gi-1].q_reg;
        end
      end
    end
  endgenerate

  logic [2:0] sync_out;
  logic       sclk_d_reg;

  assign sync_out = g_stage[SYNC_STAGES-1].q_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) sclk_d_reg <= 1'b0;
    else        sclk_d_reg <= sync_out[1];
  end

  assign cs_act    = ~sync_out[2];
  assign sclk_rise =  sync_out[1] & ~sclk_d_reg;
  assign sclk_fall = ~sync_out[1] &  sclk_d_reg;
  assign mosi_s    =  sync_out[0];

endmodule

// File: rtl/spi_sram_slave.sv
// -----------------------------------------------------------------------------
// spi_sram_slave
// Clock-synchronous SPI mode-0 SRAM slave (23LC512/1024-style commands:
// READ 03, WRITE 02, RDMR 05, WRMR 01) with byte/page/sequential modes and a
// parallel backdoor port. With SPI_SRAM_FAST_READ_EN defined, opcode 0B
// (FAST_READ: READ plus one dummy byte) is accepted; otherwise it is an
// unknown opcode.
// Ports:
//   clk, rst_n : system clock (>= 4x SCLK), synchronous active-low reset
//   bus        : spi_sram_slave_if.slave (SPI pins, busy, cmd_err, backdoor)
// -----------------------------------------------------------------------------
module spi_sram_slave #(
  parameter int ADDR_BYTES  = 2,
  parameter int MEM_DEPTH   = 65536,
  parameter int PAGE_SIZE   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_sram_slave_if.slave   bus
);
  import spi_sram_pkg::*;

  localparam int            AW        = $clog2(MEM_DEPTH);
  localparam logic [AW-1:0] PAGE_MASK = AW'(PAGE_SIZE - 1);
  localparam logic [1:0]    LAST_AB   = 2'(ADDR_BYTES - 1);

  logic cs_act, sclk_rise, sclk_fall, mosi_s;

  spi_sram_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs_n      (bus.spi_cs_n),
    .sclk      (bus.spi_sclk),
    .mosi      (bus.spi_mosi),
    .cs_act    (cs_act),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .mosi_s    (mosi_s)
  );

  state_t        state_reg, state_next;
  logic [2:0]    bit_cnt_reg;
  logic [1:0]    addr_byte_reg;
  logic [AW-1:0] addr_reg, addr_next, addr_adv;
  logic [6:0]    shift_in_reg;
  logic [7:0]    shift_out_reg;
  logic [7:0]    op_reg;
  logic [7:0]    mr_reg;
  logic          spi_miso_reg, busy_reg, cmd_err_reg;
  logic          first_load_reg, skip_fall_reg, reload_reg;
  logic [7:0]    mem_rdata_reg, bd_rdata_reg;
  logic [7:0]    mem_array [MEM_DEPTH];

  logic [7:0]    rx_byte, tx_src;
  logic          byte_done, mem_we, mr_we, set_err, adv;
  mode_t         mode;

  assign rx_byte   = {shift_in_reg, mosi_s};
  assign byte_done = sclk_rise && (bit_cnt_reg == 3'd7);
  assign mode      = mode_t'(mr_reg[7:6]);
  assign tx_src    = (state_reg == ST_RDMR) ? mr_reg : mem_rdata_reg;

  // Page mode wraps only the in-page offset; sequential wraps the whole array.
  always_comb begin
    if (mode == MODE_PAGE)
      addr_adv = (addr_reg & ~PAGE_MASK) | ((addr_reg + AW'(1)) & PAGE_MASK);
    else
      addr_adv = addr_reg + AW'(1);
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    mem_we     = 1'b0;
    mr_we      = 1'b0;
    set_err    = 1'b0;
    adv        = 1'b0;
    if (!cs_act) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: state_next = ST_CMD;
        ST_CMD: begin
          if (byte_done) begin
            addr_next = '0;
            case (rx_byte)
              OP_READ, OP_WRITE: state_next = ST_ADDR;
`ifdef SPI_SRAM_FAST_READ_EN
              OP_FAST_READ:      state_next = ST_ADDR;
`endif
              OP_RDMR:           state_next = ST_RDMR;
              OP_WRMR:           state_next = ST_WRMR;
              default: begin
                set_err    = 1'b1;
                state_next = ST_IGNORE;
              end
            endcase
          end
        end
        ST_ADDR: begin
          // Shifting into an AW-wide register drops address bits beyond the array.
          if (sclk_rise) addr_next = {addr_reg[AW-2:0], mosi_s};
          if (byte_done && addr_byte_reg == LAST_AB) begin
            if (op_reg == OP_WRITE) state_next = ST_WR_DATA;
`ifdef SPI_SRAM_FAST_READ_EN
            else if (op_reg == OP_FAST_READ) state_next = ST_DUMMY;
`endif
            else state_next = ST_RD_DATA;
          end
        end
        ST_DUMMY: if (byte_done) state_next = ST_RD_DATA;
        ST_RD_DATA, ST_WR_DATA: begin
          if (byte_done) begin
            mem_we = (state_reg == ST_WR_DATA);
            if (mode == MODE_BYTE) state_next = ST_IGNORE;
            else                   adv        = 1'b1;
          end
          if (adv) addr_next = addr_adv;
        end
        ST_WRMR: begin
          if (byte_done) begin
            mr_we      = mr_write_ok(rx_byte);
            state_next = ST_IGNORE;
          end
        end
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      bit_cnt_reg    <= '0;
      addr_byte_reg  <= '0;
      addr_reg       <= '0;
      shift_in_reg   <= '0;
      shift_out_reg  <= '0;
      op_reg         <= '0;
      mr_reg         <= MR_RESET;
      spi_miso_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      cmd_err_reg    <= 1'b0;
      first_load_reg <= 1'b0;
      skip_fall_reg  <= 1'b0;
      reload_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= cs_act;
      addr_reg  <= addr_next;
      if (set_err) cmd_err_reg <= 1'b1;
      if (mr_we)   mr_reg      <= rx_byte;

      if (state_reg == ST_IDLE) begin
        bit_cnt_reg   <= '0;
        addr_byte_reg <= '0;
      end else if (sclk_rise) begin
        shift_in_reg <= rx_byte[6:0];
        bit_cnt_reg  <= bit_cnt_reg + 3'd1;
        if (byte_done && state_reg == ST_ADDR) addr_byte_reg <= addr_byte_reg + 2'd1;
      end
      if (state_reg == ST_CMD && byte_done) begin
        op_reg        <= rx_byte;
        addr_byte_reg <= '0;
      end

      // Output side. The first byte is presented as soon as it is available
      // (no SCLK fall needed), so the fall that follows it must not shift.
      first_load_reg <= (state_next == ST_RD_DATA || state_next == ST_RDMR) &&
                        (state_next != state_reg);
      if (state_next != ST_RD_DATA && state_next != ST_RDMR) begin
        spi_miso_reg  <= 1'b0;
        skip_fall_reg <= 1'b0;
        reload_reg    <= 1'b0;
      end else if (first_load_reg) begin
        spi_miso_reg  <= tx_src[7];
        shift_out_reg <= {tx_src[6:0], 1'b0};
        skip_fall_reg <= 1'b1;
        reload_reg    <= 1'b0;
      end else if (sclk_fall) begin
        if (skip_fall_reg) begin
          skip_fall_reg <= 1'b0;
        end else if (reload_reg) begin
          spi_miso_reg  <= tx_src[7];
          shift_out_reg <= {tx_src[6:0], 1'b0};
          reload_reg    <= 1'b0;
        end else begin
          spi_miso_reg  <= shift_out_reg[7];
          shift_out_reg <= {shift_out_reg[6:0], 1'b0};
        end
      end else if (byte_done) begin
        reload_reg <= 1'b1;
      end
    end
  end

  // Single write port: an SPI commit takes the port, dropping a same-cycle
  // backdoor write. The SPI read address follows addr_next so the byte for
  // a freshly received or advanced address is ready one clock later.
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  assign wr_en   = mem_we | bus.bd_we;
  assign wr_addr = mem_we ? addr_reg : bus.bd_addr;
  assign wr_data = mem_we ? rx_byte  : bus.bd_wdata;

  always_ff @(posedge clk) begin
    if (wr_en) mem_array[wr_addr] <= wr_data;
    mem_rdata_reg <= mem_array[addr_next];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) bd_rdata_reg <= '0;
    else        bd_rdata_reg <= mem_array[bus.bd_addr];
  end

  assign bus.spi_miso = spi_miso_reg;
  assign bus.busy     = busy_reg;
  assign bus.cmd_err  = cmd_err_reg;
  assign bus.bd_rdata = bd_rdata_reg;

endmodule

// File: tb/tb_spi_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_sram_slave
// Drives spi_sram_slave as an SPI mode-0 master plus backdoor, and compares
// every MISO byte, cmd_err and backdoor read against a byte-level model of
// the SRAM command set. One line is printed per SPI transaction.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_sram_slave;

  localparam int HALF = 60;  // SCLK half period in ns (6 clk cycles)

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_sram_slave_if #(.AW(16)) bus ();

  spi_sram_slave #(
    .ADDR_BYTES(2), .MEM_DEPTH(65536), .PAGE_SIZE(32), .SYNC_STAGES(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int txn_no = 0;

  logic [7:0] mdl_mem [65536];
  logic [7:0] mdl_mr = 8'h40;
  bit         mdl_err = 1'b0;

  logic [7:0] tx_q [$];
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: expected MISO byte for each full byte of the frame, plus the
  // effect of the command on memory / mode register / error flag.
  task automatic mdl_txn(input int nbits);
    int         nfull, hdr, a, j;
    logic [7:0] op, e;
    logic [1:0] m;
    bit         is_rd, is_wr;
    nfull = nbits / 8;
    exp_q.delete();
    op    = tx_q[0];
    is_rd = (op == 8'h03);
    is_wr = (op == 8'h02);
    hdr   = 3;
`ifdef SPI_SRAM_FAST_READ_EN
    if (op == 8'h0B) begin is_rd = 1'b1; hdr = 4; end
`endif
    if (nfull >= 1 && !(is_rd || is_wr || op == 8'h05 || op == 8'h01)) mdl_err = 1'b1;
    a = (tx_q.size() >= 3) ? int'({tx_q[1], tx_q[2]}) : 0;
    for (int i = 0; i < nfull; i++) begin
      e = 8'h00;
      if (op == 8'h05 && i >= 1) begin
        e = mdl_mr;
      end else if (op == 8'h01 && i == 1) begin
        if (tx_q[1][7:6] != 2'b11) mdl_mr = tx_q[1];
      end else if ((is_rd || is_wr) && i >= hdr) begin
        j = i - hdr;
        m = mdl_mr[7:6];
        if (!(m == 2'b00 && j > 0)) begin
          if (is_rd) e = mdl_mem[a];
          else       mdl_mem[a] = tx_q[i];
        end
        if (m == 2'b10)      a = (a & ~31) | ((a + 1) & 31);
        else if (m == 2'b01) a = (a + 1) % 65536;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic spi_drive(input string tag, input int nbits);
    logic [7:0] cur, b;
    cur = 8'h00;
    rx_q.delete();
    bus.spi_cs_n = 1'b0;
    #HALF;
    for (int i = 0; i < nbits; i++) begin
      b = (i / 8 < tx_q.size()) ? tx_q[i / 8] : 8'h00;
      bus.spi_mosi = b[7 - (i % 8)];
      #HALF;
      cur = {cur[6:0], bus.spi_miso};
      if (i == 0) check({tag, "_busy_on"}, bus.busy, 1'b1);
      bus.spi_sclk = 1'b1;
      #HALF;
      bus.spi_sclk = 1'b0;
      if (i % 8 == 7) rx_q.push_back(cur);
    end
    #HALF;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    #(2 * HALF);
    check({tag, "_busy_off"}, bus.busy, 1'b0);
    check({tag, "_miso_idle"}, bus.spi_miso, 1'b0);
  endtask

  task automatic run_txn(input string tag, input int nbits);
    string s;
    mdl_txn(nbits);
    spi_drive(tag, nbits);
    s = "";
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_rx%0d", tag, i), rx_q[i], exp_q[i]);
      s = {s, $sformatf(" %02h", rx_q[i])};
    end
    check({tag, "_cmd_err"}, bus.cmd_err, mdl_err);
    txn_no++;
    $display("txn %0d %s op=%02h bits=%0d rx:%s", txn_no, tag, tx_q[0], nbits, s);
  endtask

  task automatic bd_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.bd_we = 1'b1; bus.bd_addr = a; bus.bd_wdata = d;
    @(negedge clk);
    bus.bd_we = 1'b0;
    mdl_mem[a] = d;
  endtask

  task automatic bd_check(input string tag, input logic [15:0] a);
    @(negedge clk);
    bus.bd_addr = a;
    @(negedge clk);
    check(tag, bus.bd_rdata, mdl_mem[a]);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] a;
    int          len, r;
    logic [7:0]  sel [3];
    bus.spi_cs_n = 1'b1; bus.spi_sclk = 1'b0; bus.spi_mosi = 1'b0;
    bus.bd_we = 1'b0; bus.bd_addr = '0; bus.bd_wdata = '0;
    repeat (4) @(negedge clk);
    check("rst_miso", bus.spi_miso, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_cmd_err", bus.cmd_err, 1'b0);
    check("rst_bd_rdata", bus.bd_rdata, 8'h00);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Known contents for every address the bench reads.
    for (int i = 0; i < 128; i++) bd_write(16'(i), 8'($urandom));
    for (int i = 0; i < 128; i++) bd_write(16'(16'hFF80 + i), 8'($urandom));
    bd_write(16'h1234, 8'hA5);
    bd_check("bd_1234", 16'h1234);

    tx_q = '{8'h03, 8'h12, 8'h34, 8'h00};
    run_txn("read_a5", 32);
    check("read_a5_const", rx_q[3], 8'hA5);

    tx_q = '{8'h02, 8'hFF, 8'hFF, 8'hDE, 8'hAD};
    run_txn("seq_wr_wrap", 40);
    bd_check("bd_ffff", 16'hFFFF);
    check("seq_ffff_const", mdl_mem[16'hFFFF], 8'hDE);
    bd_check("bd_0000", 16'h0000);
    tx_q = '{8'h03, 8'hFF, 8'hFF, 8'h00, 8'h00};
    run_txn("seq_rd_wrap", 40);
    check("seq_rd_de", rx_q[3], 8'hDE);
    check("seq_rd_ad", rx_q[4], 8'hAD);

    tx_q = '{8'h01, 8'h80};
    run_txn("wrmr_page", 16);
    tx_q = '{8'h02, 8'h00, 8'h1F, 8'h11, 8'h22};
    run_txn("page_wr", 40);
    bd_check("bd_001f", 16'h001F);
    bd_check("bd_0000_pg", 16'h0000);
    check("page_wrap_const", mdl_mem[0], 8'h22);
    tx_q = '{8'h05, 8'h00};
    run_txn("rdmr_80", 16);
    check("rdmr_80_const", rx_q[1], 8'h80);

    tx_q = '{8'h01, 8'h00};
    run_txn("wrmr_byte", 16);
    tx_q = '{8'h03, 8'h00, 8'h10, 8'h00, 8'h00};
    run_txn("byte_rd", 40);
    check("byte_rd_2nd_zero", rx_q[4], 8'h00);
    tx_q = '{8'h02, 8'h00, 8'h10, 8'h5A, 8'hC3};
    run_txn("byte_wr", 40);
    bd_check("bd_0010", 16'h0010);
    bd_check("bd_0011", 16'h0011);

    tx_q = '{8'h01, 8'h40};
    run_txn("wrmr_seq", 16);
    tx_q = '{8'h02, 8'h00, 8'h40, 8'hFF};
    run_txn("partial_wr", 29);
    bd_check("bd_0040", 16'h0040);
    tx_q = '{8'h03, 8'h00, 8'h40, 8'h00};
    run_txn("after_partial", 32);

    tx_q = '{8'h0B, 8'h12, 8'h34, 8'h00, 8'h00};
    run_txn("fast_read", 40);

    tx_q = '{8'h7E, 8'h00};
    run_txn("bad_op", 16);
    check("bad_op_err_const", bus.cmd_err, 1'b1);

    // Reset while selected: mode and error flag return to reset values.
    tx_q = '{8'h01, 8'h80};
    run_txn("wrmr_pre_rst", 16);
    @(negedge clk);
    bus.spi_cs_n = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    bus.spi_cs_n = 1'b1;
    repeat (12) @(negedge clk);
    mdl_mr = 8'h40;
    mdl_err = 1'b0;
    check("midrst_cmd_err", bus.cmd_err, 1'b0);
    tx_q = '{8'h05, 8'h00};
    run_txn("rdmr_after_rst", 16);

    sel = '{8'h00, 8'h40, 8'h80};
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      a   = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 16'h6F))
                                        : 16'(16'hFFF0 + $urandom_range(0, 15));
      len = $urandom_range(1, 4);
      r   = $urandom_range(0, 9);
      tx_q.delete();
      if (r <= 6) begin
        tx_q.push_back((r <= 3) ? 8'h03 : 8'h02);
        tx_q.push_back(a[15:8]);
        tx_q.push_back(a[7:0]);
        for (int k = 0; k < len; k++) tx_q.push_back(8'($urandom));
        run_txn($sformatf("rnd%0d_%s", t, (r <= 3) ? "rd" : "wr"), (3 + len) * 8);
      end else if (r == 7) begin
        tx_q.push_back(8'h01);
        tx_q.push_back(sel[$urandom_range(0, 2)] | 8'($urandom_range(0, 63)));
        run_txn($sformatf("rnd%0d_wrmr", t), 16);
      end else if (r == 8) begin
        tx_q.push_back(8'h05);
        for (int k = 0; k < len; k++) tx_q.push_back(8'h00);
        run_txn($sformatf("rnd%0d_rdmr", t), (1 + len) * 8);
      end else begin
        tx_q.push_back(8'h7E);
        tx_q.push_back(8'h00);
        run_txn($sformatf("rnd%0d_bad", t), 16);
      end
    end

    for (int i = 0; i < 128; i += 3) bd_check($sformatf("fin_lo_%0h", i), 16'(i));
    for (int i = 0; i < 128; i += 3) bd_check($sformatf("fin_hi_%0h", i), 16'(16'hFF80 + i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
